sp_instr_sequencer: RTL and testbench
=====================================

// Module: sp_instr_sequencer
// PURPOSE
//  Pops scratchpad instructions (instrFIFO_t) from the instruction FIFO and expands each into per-row requests.
//  Loads go to the DRAM load-request FIFO; stores and GEMM operand fetches go to the scratchpad read FIFO (rFIFO_t).
//  One request per cycle, in-order, one instruction in flight.
// PARAMETERS
//  WORD_W   32  address width
//  MAT_S_W  4   matrix-select width
//  ROW_S_W  2   row-select width; rows per matrix R = 2**ROW_S_W (4)
//  STRIDE   8   byte address increment per row (64-bit row)
// PORTS
//  CLK          in   1   clock
//  RST          in   1   reset, synchronous, active-high
//  instr_empty  in   1   instruction FIFO empty
//  instr_rdata  in   38  {opcode[1:0], mat[3:0], word[31:0]} (instrFIFO_t)
//  instr_ren    out  1   pop instruction FIFO
//  ld_full      in   1   load-request FIFO full
//  ld_wen       out  1   push load request
//  ld_wdata     out  38  {addr[31:0], mat_s[3:0], row_s[1:0]}
//  rd_full      in   1   read FIFO full
//  rd_wen       out  1   push read request
//  rd_wdata     out  40  rFIFO_t {addr[31:0], mat_t[1:0], mat_s[3:0], row_s[1:0]}
//  busy         out  1   instruction in flight (state != IDLE)
//  instr_done   out  1   1-cycle pulse, same cycle as the last push of an instruction
// BEHAVIOUR
//  Reset: state=IDLE, row=0, all outputs 0 (instr_ren, ld_wen, rd_wen, busy, instr_done, wdata).
//    RST mid-instruction aborts it; no further pushes; captured instruction discarded.
//  Opcodes: 00 NOP, 01 LOAD, 10 STORE, 11 GEMM.
//  IDLE: instr_ren = !instr_empty (combinational); on pop, register instr; row=0.
//    LOAD->S_LOAD, STORE->S_STORE.
//    GEMM->S_GW if mat[3] (new weight), else S_GI.
//    NOP: consumed, stays IDLE, no instr_done.
//  Latency: pop in cycle N -> first push earliest in cycle N+1. Back-to-back instructions: next pop in the cycle after instr_done.
//  S_LOAD: ld_wen=!ld_full; ld_wdata={base+row*STRIDE, mat, row}.
//  S_STORE: rd_wen=!rd_full; rd_wdata={base+row*STRIDE, 2'b00, mat, row}.
//  GEMM: gemm_sel = word[15:0].
//    Weight matrix = sel[11:8]; input = sel[7:4]; psum = sel[3:0].
//    Other sel bits ignored. addr=0.
//    S_GW pushes mat_t=01, S_GI pushes mat_t=10, S_GP pushes mat_t=11.
//    Each via rd_wen=!rd_full. Order S_GW -> S_GI -> S_GP -> IDLE.
//  Row counter: rows 0..R-1 ascending. Increment only on an accepted push (wen=1).
//    On the push of row R-1: wrap row to 0 and advance state.
//    instr_done=1 on the final push (row R-1 of S_LOAD/S_STORE/S_GP).
//  Backpressure: full=1 -> wen=0, row and state hold, wdata holds current value.
//    No push is ever issued while full=1.
//  Address arithmetic: WORD_W-bit, modulo 2**WORD_W (wraps past 0xFFFF_FFFF); no alignment check.
//  ld_wen and rd_wen never both 1. instr_ren never 1 while busy.
//  wdata: don't-care when its wen=0, but must be stable while stalled.
// TESTING
//  1 LOAD mat=3 addr=0x1000, fifos never full -> ld pushes on 4 consecutive cycles:
//    {0x1000,3,0}, {0x1008,3,1}, {0x1010,3,2}, {0x1018,3,3}.
//    instr_done with 4th push; rd_wen never asserts.
//  2 STORE mat=5 addr=0xFFFF_FFF8 -> rd entries mat_t=00, mat_s=5, addrs 0xFFFF_FFF8, 0x0, 0x8, 0x10 (wrap).
//  3 GEMM mat=4'b1000 sel=0x0A21 -> 12 rd pushes, all addr=0:
//    mat_t=01 mat_s=0xA rows 0-3; mat_t=10 mat_s=2 rows 0-3; mat_t=11 mat_s=1 rows 0-3.
//  4 GEMM mat=4'b0000 sel=0x0A21 -> 8 pushes only (mat_t=10 then 11); no mat_t=01 entries.
//  5 Backpressure: STORE; hold rd_full=1 for 3 cycles after the 2nd push.
//    -> no push during stall, row 2 entry unchanged, then rows 2,3 pushed; total exactly 4 entries.
//  6 NOP then LOAD queued -> NOP popped with no push and no instr_done; LOAD popped next cycle.
//    RST asserted after 2nd LOAD push -> next cycle all outputs 0, busy=0, no further pushes.

Source files
------------

// File: rtl/sp_instr_sequencer.sv
// Expands scratchpad instructions into per-row load or read requests, one request per cycle, in order.
// First push is one cycle after the pop. A full FIFO holds the row, the state and wdata.
module sp_instr_sequencer #(
    parameter int WORD_W  = 32,
    parameter int MAT_S_W = 4,
    parameter int ROW_S_W = 2,
    parameter int STRIDE  = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_instr_empty,
    input  logic [WORD_W+MAT_S_W+1:0]             i_instr_rdata,
    output logic                                  o_instr_ren,
    input  logic                                  i_ld_full,
    output logic                                  o_ld_wen,
    output logic [WORD_W+MAT_S_W+ROW_S_W-1:0]     o_ld_wdata,
    input  logic                                  i_rd_full,
    output logic                                  o_rd_wen,
    output logic [WORD_W+2+MAT_S_W+ROW_S_W-1:0]   o_rd_wdata,
    output logic                                  o_busy,
    output logic                                  o_instr_done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STORE = 3'd2;
    localparam logic [2:0] S_GW    = 3'd3;
    localparam logic [2:0] S_GI    = 3'd4;
    localparam logic [2:0] S_GP    = 3'd5;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_GEMM  = 2'b11;

    localparam logic [WORD_W-1:0] LP_STRIDE = WORD_W'(STRIDE);

    logic [2:0]         r_state;
    logic [ROW_S_W-1:0] r_row;
    logic [WORD_W-1:0]  r_base;
    logic [MAT_S_W-1:0] r_mat;

    logic [1:0]         w_op_in;
    logic [MAT_S_W-1:0] w_mat_in;
    logic [WORD_W-1:0]  w_word_in;
    logic               w_pop;
    logic               w_is_ld;
    logic               w_is_rd;
    logic               w_is_gemm;
    logic               w_ld_push;
    logic               w_rd_push;
    logic               w_push;
    logic               w_last_row;
    logic [WORD_W-1:0]  w_offset;
    logic [WORD_W-1:0]  w_addr;
    logic [1:0]         w_mat_t;
    logic [MAT_S_W-1:0] w_rd_mat_s;
    logic [2:0]         w_next_state;

    assign w_op_in   = i_instr_rdata[WORD_W+MAT_S_W+1 -: 2];
    assign w_mat_in  = i_instr_rdata[WORD_W+MAT_S_W-1 -: MAT_S_W];
    assign w_word_in = i_instr_rdata[WORD_W-1:0];

    // Reset gates every strobe so an aborted instruction cannot leak a push in the reset cycle.
    assign w_pop      = (r_state == IDLE) && !i_instr_empty && !i_rst;
    assign w_is_ld    = (r_state == S_LOAD);
    assign w_is_gemm  = (r_state == S_GW) || (r_state == S_GI) || (r_state == S_GP);
    assign w_is_rd    = (r_state == S_STORE) || w_is_gemm;
    assign w_ld_push  = w_is_ld && !i_ld_full && !i_rst;
    assign w_rd_push  = w_is_rd && !i_rd_full && !i_rst;
    assign w_push     = w_ld_push || w_rd_push;
    assign w_last_row = &r_row;

    assign w_offset = WORD_W'(r_row) * LP_STRIDE;
    assign w_addr   = w_is_gemm ? '0 : r_base + w_offset;

    // GEMM operand selects live in the low bits of the captured word: weight, input, psum.
    always_comb begin
        w_mat_t    = 2'b00;
        w_rd_mat_s = r_mat;
        case (r_state)
            S_GW: begin
                w_mat_t    = 2'b01;
                w_rd_mat_s = r_base[3*MAT_S_W-1:2*MAT_S_W];
            end
            S_GI: begin
                w_mat_t    = 2'b10;
                w_rd_mat_s = r_base[2*MAT_S_W-1:MAT_S_W];
            end
            S_GP: begin
                w_mat_t    = 2'b11;
                w_rd_mat_s = r_base[MAT_S_W-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            S_GW:    w_next_state = S_GI;
            S_GI:    w_next_state = S_GP;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_base  <= '0;
            r_mat   <= '0;
        end else if (r_state == IDLE) begin
            if (w_pop) begin
                r_base <= w_word_in;
                r_mat  <= w_mat_in;
                r_row  <= '0;
                case (w_op_in)
                    OP_LOAD:  r_state <= S_LOAD;
                    OP_STORE: r_state <= S_STORE;
                    OP_GEMM:  r_state <= w_mat_in[MAT_S_W-1] ? S_GW : S_GI;
                    default:  r_state <= IDLE;
                endcase
            end
        end else if (w_push) begin
            if (w_last_row) begin
                r_row   <= '0;
                r_state <= w_next_state;
            end else begin
                r_row <= r_row + ROW_S_W'(1);
            end
        end
    end

    assign o_instr_ren  = w_pop;
    assign o_ld_wen     = w_ld_push;
    assign o_rd_wen     = w_rd_push;
    assign o_ld_wdata   = {w_addr, r_mat, r_row};
    assign o_rd_wdata   = {w_addr, w_mat_t, w_rd_mat_s, r_row};
    assign o_busy       = (r_state != IDLE);
    assign o_instr_done = w_push && w_last_row &&
                          ((r_state == S_LOAD) || (r_state == S_STORE) || (r_state == S_GP));

endmodule

// File: tb/tb_sp_instr_sequencer.sv
// Directed bench for sp_instr_sequencer: queued instructions, logged pushes, hand-computed expectations.
module tb_sp_instr_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_instr_empty;
    logic [37:0] i_instr_rdata;
    logic        o_instr_ren;
    logic        i_ld_full;
    logic        o_ld_wen;
    logic [37:0] o_ld_wdata;
    logic        i_rd_full;
    logic        o_rd_wen;
    logic [39:0] o_rd_wdata;
    logic        o_busy;
    logic        o_instr_done;

    sp_instr_sequencer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_instr_empty (i_instr_empty),
        .i_instr_rdata (i_instr_rdata),
        .o_instr_ren   (o_instr_ren),
        .i_ld_full     (i_ld_full),
        .o_ld_wen      (o_ld_wen),
        .o_ld_wdata    (o_ld_wdata),
        .i_rd_full     (i_rd_full),
        .o_rd_wen      (o_rd_wen),
        .o_rd_wdata    (o_rd_wdata),
        .o_busy        (o_busy),
        .o_instr_done  (o_instr_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [39:0] dat;
        int          cyc;
        logic        done;
    } ent_t;

    logic [37:0] iq[$];
    ent_t        ld_log[$];
    ent_t        rd_log[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          viol = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic        pop_pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [37:0] mk(input logic [1:0] op, input logic [3:0] m, input logic [31:0] w);
        return {op, m, w};
    endfunction

    // Observe outputs mid-cycle and log every accepted push.
    always @(negedge i_clk) begin
        ent_t e;
        cyc++;
        if (o_instr_ren) begin
            pop_pend = 1'b1;
            pop_cyc.push_back(cyc);
            if (o_busy) viol++;
        end
        if (o_ld_wen) begin
            e.dat = {2'b00, o_ld_wdata};
            e.cyc = cyc;
            e.done = o_instr_done;
            ld_log.push_back(e);
            if (i_ld_full) viol++;
        end
        if (o_rd_wen) begin
            e.dat = o_rd_wdata;
            e.cyc = cyc;
            e.done = o_instr_done;
            rd_log.push_back(e);
            if (i_rd_full) viol++;
        end
        if (o_ld_wen && o_rd_wen) viol++;
        if (o_instr_done) begin
            done_cnt++;
            if (!o_ld_wen && !o_rd_wen) viol++;
        end
    end

    // Instruction FIFO model: pop on the edge where ren was seen high.
    always @(posedge i_clk) begin
        #1;
        if (pop_pend) begin
            if (iq.size() > 0) void'(iq.pop_front());
            pop_pend = 1'b0;
        end
        i_instr_empty = (iq.size() == 0);
        i_instr_rdata = (iq.size() > 0) ? iq[0] : '0;
    end

    task automatic clear_logs();
        ld_log.delete();
        rd_log.delete();
        pop_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while ((iq.size() != 0 || o_busy || pop_pend) && n < 300);
        chk({tag, "_timeout"}, 64'(n >= 300), 64'd0);
    endtask

    initial begin
        logic [39:0] exp_ld[4];
        logic [39:0] exp_st[4];
        logic [1:0]  g_mt[3];
        logic [3:0]  g_ms[3];
        int          n;

        i_rst = 1'b1;
        i_ld_full = 1'b0;
        i_rd_full = 1'b0;
        i_instr_empty = 1'b1;
        i_instr_rdata = '0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ren",   64'(o_instr_ren), 64'd0);
        chk("rst_ldwen", 64'(o_ld_wen), 64'd0);
        chk("rst_rdwen", 64'(o_rd_wen), 64'd0);
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_done",  64'(o_instr_done), 64'd0);
        chk("rst_lddat", 64'(o_ld_wdata), 64'd0);
        chk("rst_rddat", 64'(o_rd_wdata), 64'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // 1: LOAD mat=3 addr=0x1000
        clear_logs();
        exp_ld[0] = {2'b00, 32'h0000_1000, 4'd3, 2'd0};
        exp_ld[1] = {2'b00, 32'h0000_1008, 4'd3, 2'd1};
        exp_ld[2] = {2'b00, 32'h0000_1010, 4'd3, 2'd2};
        exp_ld[3] = {2'b00, 32'h0000_1018, 4'd3, 2'd3};
        iq.push_back(mk(2'b01, 4'd3, 32'h0000_1000));
        wait_idle("t1");
        chk("t1_ld_cnt", 64'(ld_log.size()), 64'd4);
        chk("t1_rd_cnt", 64'(rd_log.size()), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_latency", 64'(ld_log.size() > 0 && pop_cyc.size() > 0 ? ld_log[0].cyc - pop_cyc[0] : -1), 64'd1);
        for (int i = 0; i < 4 && i < ld_log.size(); i++) begin
            chk($sformatf("t1_dat%0d", i), 64'(ld_log[i].dat), 64'(exp_ld[i]));
            chk($sformatf("t1_cyc%0d", i), 64'(ld_log[i].cyc - ld_log[0].cyc), 64'(i));
            chk($sformatf("t1_done%0d", i), 64'(ld_log[i].done), 64'(i == 3));
        end

        // 2: STORE mat=5 addr wraps past 0xFFFF_FFFF
        clear_logs();
        exp_st[0] = {32'hFFFF_FFF8, 2'b00, 4'd5, 2'd0};
        exp_st[1] = {32'h0000_0000, 2'b00, 4'd5, 2'd1};
        exp_st[2] = {32'h0000_0008, 2'b00, 4'd5, 2'd2};
        exp_st[3] = {32'h0000_0010, 2'b00, 4'd5, 2'd3};
        iq.push_back(mk(2'b10, 4'd5, 32'hFFFF_FFF8));
        wait_idle("t2");
        chk("t2_rd_cnt", 64'(rd_log.size()), 64'd4);
        chk("t2_ld_cnt", 64'(ld_log.size()), 64'd0);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chk($sformatf("t2_dat%0d", i), 64'(rd_log[i].dat), 64'(exp_st[i]));

        // 3: GEMM with new weight, sel=0x0A21
        g_mt[0] = 2'b01; g_mt[1] = 2'b10; g_mt[2] = 2'b11;
        g_ms[0] = 4'hA;  g_ms[1] = 4'h2;  g_ms[2] = 4'h1;
        clear_logs();
        iq.push_back(mk(2'b11, 4'b1000, 32'h0000_0A21));
        wait_idle("t3");
        chk("t3_rd_cnt", 64'(rd_log.size()), 64'd12);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 12 && i < rd_log.size(); i++) begin
            chk($sformatf("t3_dat%0d", i), 64'(rd_log[i].dat),
                64'({32'h0, g_mt[i/4], g_ms[i/4], 2'(i % 4)}));
            chk($sformatf("t3_done%0d", i), 64'(rd_log[i].done), 64'(i == 11));
        end

        // 4: GEMM reusing weight -> input and psum phases only
        clear_logs();
        iq.push_back(mk(2'b11, 4'b0000, 32'h0000_0A21));
        wait_idle("t4");
        chk("t4_rd_cnt", 64'(rd_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < rd_log.size(); i++)
            chk($sformatf("t4_dat%0d", i), 64'(rd_log[i].dat),
                64'({32'h0, g_mt[1 + i/4], g_ms[1 + i/4], 2'(i % 4)}));

        // 5: STORE with a 3-cycle stall after the second push
        clear_logs();
        iq.push_back(mk(2'b10, 4'd6, 32'h0000_0200));
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (rd_log.size() < 2 && n < 100);
        chk("t5_wait_timeout", 64'(n >= 100), 64'd0);
        i_rd_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk($sformatf("t5_stall_wen%0d", i), 64'(o_rd_wen), 64'd0);
            chk($sformatf("t5_stall_dat%0d", i), 64'(o_rd_wdata),
                64'({32'h0000_0210, 2'b00, 4'd6, 2'd2}));
        end
        @(posedge i_clk);
        #1 i_rd_full = 1'b0;
        wait_idle("t5");
        chk("t5_rd_cnt", 64'(rd_log.size()), 64'd4);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chk($sformatf("t5_dat%0d", i), 64'(rd_log[i].dat),
                64'({32'h0000_0200 + 32'(8 * i), 2'b00, 4'd6, 2'(i)}));
        if (rd_log.size() >= 3)
            chk("t5_gap", 64'(rd_log[2].cyc - rd_log[1].cyc), 64'd4);

        // 6: NOP then LOAD, reset after the LOAD's second push
        clear_logs();
        iq.push_back(mk(2'b00, 4'd7, 32'hDEAD_BEEF));
        iq.push_back(mk(2'b01, 4'd2, 32'h0000_0040));
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (ld_log.size() < 2 && n < 100);
        chk("t6_wait_timeout", 64'(n >= 100), 64'd0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("t6_rst_busy",  64'(o_busy), 64'd0);
        chk("t6_rst_ldwen", 64'(o_ld_wen), 64'd0);
        chk("t6_rst_rdwen", 64'(o_rd_wen), 64'd0);
        chk("t6_rst_ren",   64'(o_instr_ren), 64'd0);
        chk("t6_rst_lddat", 64'(o_ld_wdata), 64'd0);
        chk("t6_rst_rddat", 64'(o_rd_wdata), 64'd0);
        repeat (8) @(posedge i_clk);
        #1;
        chk("t6_pop_cnt", 64'(pop_cyc.size()), 64'd2);
        if (pop_cyc.size() == 2) begin
            chk("t6_pop_gap", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
            if (ld_log.size() > 0)
                chk("t6_first_push", 64'(ld_log[0].cyc - pop_cyc[1]), 64'd1);
        end
        chk("t6_ld_cnt", 64'(ld_log.size()), 64'd2);
        chk("t6_rd_cnt", 64'(rd_log.size()), 64'd0);
        chk("t6_done_cnt", 64'(done_cnt), 64'd0);
        for (int i = 0; i < 2 && i < ld_log.size(); i++)
            chk($sformatf("t6_dat%0d", i), 64'(ld_log[i].dat),
                64'({2'b00, 32'h0000_0040 + 32'(8 * i), 4'd2, 2'(i)}));

        chk("protocol_violations", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
